uart_tx_multi: RTL and testbench

Parametrised serial transmitter, the successor to the fixed 8N1 transmitter in the riscv_core UART.
- Frame format is configurable at runtime: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits.
- An input FIFO decouples the CPU MMIO store path from the serial line, so frames go out back to back.
- Sits between the memory-mapped UART register interface and the FPGA TX pin.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_fifo.sv | 71 +++++++
 rtl/uart_tx_multi.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_multi.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared encodings, FSM state type and timing helper for the
//               multi-format UART transmitter (and the future receiver).
//               The BREAK state exists only when UART_TX_BREAK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Parity-mode encodings of cfg_parity; 2'b11 is reserved and behaves as none
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Data-bit encodings of cfg_data_bits
  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  // Transmit engine states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    S_BREAK  = 3'd5
`endif
  } tx_state_t;

  // Bit-cell length in core clocks (truncated division)
  function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
// Module      : uart_fifo
// Description : Generic synchronous FIFO with first-word fall-through read.
//               Push is ignored when full, pop is ignored when empty.
//               DEPTH must be a power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop keeps the count
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_multi.sv
// ============================================================================
// Module      : uart_tx_multi
// Description : FIFO-buffered serial transmitter with runtime frame format
//               (5-8 data bits, none/even/odd parity, 1 or 2 stop bits).
//               serial_out is registered, so the line lags the engine state
//               by one clock. Optional line-break generation is enabled by
//               defining UART_TX_BREAK_EN (adds the break_req input).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_multi
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                          break_req,
`endif
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

  tx_state_t        r_state;
  logic [CNT_W-1:0] r_cell_cnt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       r_last_idx;
  logic [7:0]       r_shift;
  logic             r_par_en;
  logic             r_par_bit;
  logic             r_stop2;

  logic [7:0]       w_fifo_dout;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_break;
  logic             w_cell_end;
  logic             w_stop_done;
  logic             w_pop;
  logic [7:0]       w_mask;
  logic             w_par_en;
  logic             w_par_bit;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_in_valid),
    .pop   (w_pop),
    .din   (data_in),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (fifo_count)
  );

`ifdef UART_TX_BREAK_EN
  assign w_break = break_req;
`else
  assign w_break = 1'b0;
`endif

  assign data_in_ready = !w_fifo_full;
  assign busy          = (r_state != S_IDLE) || (fifo_count != '0);

  assign w_cell_end  = (r_cell_cnt == CNT_W'(CYCLES_PER_BIT - 1));
  // r_bit_idx counts stop cells here: done after cell 0 (one stop) or cell 1 (two)
  assign w_stop_done = (r_state == S_STOP) && w_cell_end && (r_bit_idx[0] == r_stop2);
  // A pending break takes priority over starting the next frame
  assign w_pop       = !w_fifo_empty && !w_break && ((r_state == S_IDLE) || w_stop_done);

  // Frame attributes derived from the cfg inputs at the moment of the pop
  assign w_mask    = 8'hFF >> (2'd3 - cfg_data_bits);
  assign w_par_en  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
  assign w_par_bit = (^(w_fifo_dout & w_mask)) ^ (cfg_parity == PAR_ODD);

  // Transmit engine: drives the registered line level for the current state
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      serial_out <= 1'b1;
      r_cell_cnt <= '0;
      r_bit_idx  <= '0;
      r_last_idx <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
    end else begin
      r_cell_cnt <= (r_state == S_IDLE || w_cell_end) ? '0 : r_cell_cnt + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          serial_out <= 1'b1;
          if (w_pop) begin
            r_state <= S_START;
          end
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            r_state <= S_BREAK;
          end
`endif
        end

        S_START: begin
          serial_out <= 1'b0;
          if (w_cell_end) begin
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end
        end

        S_DATA: begin
          serial_out <= r_shift[0];
          if (w_cell_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == r_last_idx) begin
              r_bit_idx <= '0;
              r_state   <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end

        S_PARITY: begin
          serial_out <= r_par_bit;
          if (w_cell_end) begin
            r_bit_idx <= '0;
            r_state   <= S_STOP;
          end
        end

        S_STOP: begin
          serial_out <= 1'b1;
          if (w_cell_end) begin
            if (w_stop_done) begin
              r_bit_idx <= '0;
              r_state   <= w_pop ? S_START : S_IDLE;
`ifdef UART_TX_BREAK_EN
              if (break_req) begin
                r_state <= S_BREAK;
              end
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end

`ifdef UART_TX_BREAK_EN
        // Hold the line low; on release reuse a single stop cell as the high guard
        S_BREAK: begin
          serial_out <= 1'b0;
          r_cell_cnt <= '0;
          if (!break_req) begin
            r_bit_idx <= '0;
            r_stop2   <= 1'b0;
            r_state   <= S_STOP;
          end
        end
`endif

        default: begin
          serial_out <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase

      // Latch the popped word together with its frame format
      if (w_pop) begin
        r_shift    <= w_fifo_dout;
        r_last_idx <= 3'd4 + {1'b0, cfg_data_bits};
        r_par_en   <= w_par_en;
        r_par_bit  <= w_par_bit;
        r_stop2    <= cfg_stop2;
        r_bit_idx  <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_multi.sv
// ============================================================================
// Module      : tb_uart_tx_multi
// Description : Self-checking bench for uart_tx_multi (default build, no
//               break feature). A queue-based frame model predicts the line,
//               busy, fifo_count and data_in_ready every cycle; directed
//               frames pin exact bit patterns and timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_multi;

  localparam int CPB   = 10;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic [1:0] cfg_data_bits = 2'b11;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic       serial_out;
  logic       busy;
  logic [3:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  uart_tx_multi #(
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .serial_out    (serial_out),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ordered list of line levels for one frame: start, N data LSB first, parity, stops
  function automatic logic [11:0] frame_bits(input logic [7:0] w, input logic [1:0] db,
                                             input logic [1:0] par, input logic s2,
                                             output int len);
    int n;
    logic p;
    logic [11:0] f;
    n = 5 + int'(db);
    p = 1'b0;
    f = '0;
    len = 1;
    for (int i = 0; i < n; i++) begin
      f[len] = w[i];
      p = p ^ w[i];
      len++;
    end
    if (par == 2'b01 || par == 2'b10) begin
      f[len] = (par == 2'b10) ? ~p : p;
      len++;
    end
    f[len] = 1'b1;
    len++;
    if (s2) begin
      f[len] = 1'b1;
      len++;
    end
    return f;
  endfunction

  // Reference model: FIFO contents plus the per-cycle line levels still owed
  logic [7:0]  m_fifo[$];
  logic        m_line_q[$];
  logic        m_line = 1'b1;
  logic [11:0] m_bits;
  logic [7:0]  m_word;
  int          m_len;
  bit          m_do_pop;
  bit          m_do_push;

  always @(posedge clk) begin
    if (!reset) begin
      m_fifo.delete();
      m_line_q.delete();
      m_line = 1'b1;
    end else begin
      m_do_pop  = (m_line_q.size() <= 1) && (m_fifo.size() != 0);
      m_do_push = data_in_valid && (m_fifo.size() != DEPTH);
      m_line    = (m_line_q.size() != 0) ? m_line_q.pop_front() : 1'b1;
      if (m_do_pop) begin
        m_word = m_fifo.pop_front();
        m_bits = frame_bits(m_word, cfg_data_bits, cfg_parity, cfg_stop2, m_len);
        for (int i = 0; i < m_len; i++)
          for (int j = 0; j < CPB; j++)
            m_line_q.push_back(m_bits[i]);
      end
      if (m_do_push) m_fifo.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("serial_out", {31'd0, serial_out}, {31'd0, m_line});
      chk("busy", {31'd0, busy}, ((m_line_q.size() != 0) || (m_fifo.size() != 0)) ? 1 : 0);
      chk("fifo_count", {28'd0, fifo_count}, m_fifo.size());
      chk("data_in_ready", {31'd0, data_in_ready}, (m_fifo.size() != DEPTH) ? 1 : 0);
    end
  end

  task automatic push_one(input logic [7:0] w);
    @(negedge clk);
    data_in       = w;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
  endtask

  // Push one word into an idle transmitter; measure start latency, mid-cell bits, busy fall
  task automatic run_frame(input logic [7:0] w, input int ncells, output int lat,
                           output logic [11:0] bits, output int busy_fall);
    int off;
    push_one(w);
    lat = -1;
    busy_fall = -1;
    bits = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (lat < 0 && serial_out == 1'b0) lat = k;
      if (lat >= 0) begin
        off = k - lat - 4;
        if (off >= 0 && (off % CPB) == 0 && (off / CPB) < ncells) bits[off / CPB] = serial_out;
      end
      if (busy == 1'b0) begin
        busy_fall = k;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(name, (busy === 1'b0) ? 1 : 0, 1);
  endtask

  initial begin
    logic [11:0] bits;
    int lat, bf, acc, bad;

    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_serial_out", {31'd0, serial_out}, 1);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_fifo_count", {28'd0, fifo_count}, 0);
    chk("reset_ready", {31'd0, data_in_ready}, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1, 0x55
    cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    run_frame(8'h55, 10, lat, bits, bf);
    chk("8N1_latency", lat, 2);
    chk("8N1_bits", {20'd0, bits}, 12'h2AA);
    chk("8N1_busy_fall", bf, 101);

    // 7E1, 0xC1 (bit 7 must be ignored)
    cfg_data_bits = 2'b10; cfg_parity = 2'b01; cfg_stop2 = 1'b0;
    run_frame(8'hC1, 10, lat, bits, bf);
    chk("7E1_latency", lat, 2);
    chk("7E1_bits", {20'd0, bits}, 12'h282);
    chk("7E1_busy_fall", bf, 101);

    // 8O2, 0x00
    cfg_data_bits = 2'b11; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
    run_frame(8'h00, 12, lat, bits, bf);
    chk("8O2_bits", {20'd0, bits}, 12'hE00);
    chk("8O2_busy_fall", bf, 121);

    // Continuous valid into an idle transmitter
    cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      data_in = 8'($urandom);
      data_in_valid = 1'b1;
      if (data_in_ready) acc++;
    end
    @(negedge clk);
    data_in_valid = 1'b0;
    chk("burst_accepted", acc, 9);
    wait_idle("burst_drain", 2000);

    // Config change mid-frame: 8N1 then 5E2 for the queued word
    push_one(8'hA5);
    push_one(8'h3C);
    bf = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 20) begin
        cfg_data_bits = 2'b00; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
      end
      if (busy == 1'b0) begin
        bf = k;
        break;
      end
    end
    chk("cfg_change_busy_fall", bf, 190);

    // Reset during DATA with three words queued
    cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    for (int i = 0; i < 4; i++) push_one(8'(8'h11 * (i + 1)));
    repeat (25) @(negedge clk);
    chk("pre_reset_count", {28'd0, fifo_count}, 3);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_serial_out", {31'd0, serial_out}, 1);
    chk("abort_fifo_count", {28'd0, fifo_count}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    reset = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (serial_out !== 1'b1) bad++;
    end
    chk("post_reset_idle", bad, 0);

    // Randomized traffic: alternating dense/sparse load, cfg changes, rare resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      data_in = 8'($urandom);
      if (((c / 500) % 2) == 0) data_in_valid = ($urandom_range(0, 3) == 0);
      else                      data_in_valid = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 59) == 0) begin
        cfg_data_bits = 2'($urandom);
        cfg_parity    = 2'($urandom);
        cfg_stop2     = 1'($urandom);
      end
      reset = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);
    data_in_valid = 1'b0;
    reset = 1'b1;
    wait_idle("final_drain", 2500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
